// File: rtl/status_flags.sv
// 6502 processor status register (P) with PHP/PLP formatting, BIT support,
// and IRQ/NMI synchronization, pending and take logic for the sequencer.
module status_flags #(
  parameter logic RESET_I  = 1'b1,
  parameter int   NMI_SYNC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_valid,
  input  logic       upd_n,
  input  logic       upd_z,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic [7:0] operand,
  input  logic       set_c,
  input  logic       clr_c,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       set_d,
  input  logic       clr_d,
  input  logic       clr_v,
  input  logic       plp_load,
  input  logic [7:0] pull_data,
  input  logic       push_brk,
  output logic [7:0] p_push,
  output logic       flag_n,
  output logic       flag_v,
  output logic       flag_d,
  output logic       flag_i,
  output logic       flag_z,
  output logic       flag_c,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       poll,
  input  logic       int_ack,
  output logic       irq_take,
  output logic       nmi_take
);

  logic n_q, n_d, v_q, v_d, d_q, d_d, i_q, i_d, z_q, z_d, c_q, c_d;
  logic [NMI_SYNC-1:0] irq_sync_q, nmi_sync_q;
  logic nmi_prev_q;
  logic nmi_pending_q, nmi_pending_d;
  logic i_delayed_q;
  logic irq_take_q, irq_take_d, nmi_take_q, nmi_take_d;
  logic nmi_fall, irq_pend, alu_zero;
  logic unused_inputs;

  assign unused_inputs = ^{pull_data[5:4], operand[5:0]};
  assign alu_zero = ~|alu_result;

  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (plp_load) begin
      n_d = pull_data[7];
      v_d = pull_data[6];
      d_d = pull_data[3];
      i_d = pull_data[2];
      z_d = pull_data[1];
      c_d = pull_data[0];
    end else begin
      // Per-flag priority chains: clr beats set, explicit beats BIT beats ALU.
      if (bit_op)                n_d = operand[7];
      else if (alu_valid && upd_n) n_d = alu_result[7];

      if (clr_v)                 v_d = 1'b0;
      else if (bit_op)           v_d = operand[6];
      else if (alu_valid && upd_v) v_d = alu_overflow;

      if (clr_d)                 d_d = 1'b0;
      else if (set_d)            d_d = 1'b1;

      if (clr_i)                 i_d = 1'b0;
      else if (set_i)            i_d = 1'b1;

      if (alu_valid && (bit_op || upd_z)) z_d = alu_zero;

      if (clr_c)                 c_d = 1'b0;
      else if (set_c)            c_d = 1'b1;
      else if (alu_valid && upd_c) c_d = alu_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
      d_q <= 1'b0;
      i_q <= RESET_I;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign {flag_n, flag_v, flag_d, flag_i, flag_z, flag_c} = {n_q, v_q, d_q, i_q, z_q, c_q};
  assign p_push = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};

  assign nmi_fall = nmi_prev_q & ~nmi_sync_q[NMI_SYNC-1];
  assign irq_pend = ~irq_sync_q[NMI_SYNC-1] & ~i_delayed_q;

  always_comb begin
    nmi_pending_d = nmi_fall | (nmi_pending_q & ~(int_ack & nmi_take_q));
    irq_take_d    = irq_take_q;
    nmi_take_d    = nmi_take_q;
    if (int_ack) begin
      irq_take_d = 1'b0;
      nmi_take_d = 1'b0;
    end else if (poll) begin
      nmi_take_d = nmi_pending_q;
      irq_take_d = irq_pend & ~nmi_pending_q;
    end else if (!nmi_pending_q && !irq_pend) begin
      irq_take_d = 1'b0;
      nmi_take_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync_q    <= '1;
      nmi_sync_q    <= '1;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      i_delayed_q   <= RESET_I;
      irq_take_q    <= 1'b0;
      nmi_take_q    <= 1'b0;
    end else begin
      irq_sync_q[0] <= irq_n;
      nmi_sync_q[0] <= nmi_n;
      for (int k = 1; k < NMI_SYNC; k++) begin
        irq_sync_q[k] <= irq_sync_q[k-1];
        nmi_sync_q[k] <= nmi_sync_q[k-1];
      end
      nmi_prev_q    <= nmi_sync_q[NMI_SYNC-1];
      nmi_pending_q <= nmi_pending_d;
      i_delayed_q   <= i_q;
      irq_take_q    <= irq_take_d;
      nmi_take_q    <= nmi_take_d;
    end
  end

  assign irq_take = irq_take_q;
  assign nmi_take = nmi_take_q;

endmodule

// File: tb/tb_status_flags.sv
// Directed bench for status_flags: expectations queued with the stimulus,
// popped and asserted after each sampled clock edge.
module tb_status_flags;

  localparam int SEL_FLAGS = 0;
  localparam int SEL_PUSH  = 1;
  localparam int SEL_IRQ   = 2;
  localparam int SEL_NMI   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_result, operand, pull_data, p_push;
  logic       alu_carry, alu_overflow, alu_valid;
  logic       upd_n, upd_z, upd_c, upd_v, bit_op;
  logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
  logic       plp_load, push_brk;
  logic       flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
  logic       irq_n, nmi_n, poll, int_ack, irq_take, nmi_take;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  status_flags #(.RESET_I(1'b1), .NMI_SYNC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_valid(alu_valid), .upd_n(upd_n), .upd_z(upd_z), .upd_c(upd_c), .upd_v(upd_v),
    .bit_op(bit_op), .operand(operand),
    .set_c(set_c), .clr_c(clr_c), .set_i(set_i), .clr_i(clr_i),
    .set_d(set_d), .clr_d(clr_d), .clr_v(clr_v),
    .plp_load(plp_load), .pull_data(pull_data), .push_brk(push_brk), .p_push(p_push),
    .flag_n(flag_n), .flag_v(flag_v), .flag_d(flag_d), .flag_i(flag_i),
    .flag_z(flag_z), .flag_c(flag_c),
    .irq_n(irq_n), .nmi_n(nmi_n), .poll(poll), .int_ack(int_ack),
    .irq_take(irq_take), .nmi_take(nmi_take)
  );

  function automatic logic [7:0] observe(int sel);
    case (sel)
      SEL_FLAGS: return {2'b00, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c};
      SEL_PUSH:  return p_push;
      SEL_IRQ:   return {7'd0, irq_take};
      default:   return {7'd0, nmi_take};
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      n_total++;
      assert (o === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
    end
  endtask

  task automatic idle();
    {alu_carry, alu_overflow, alu_valid, upd_n, upd_z, upd_c, upd_v, bit_op} = '0;
    {set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, plp_load, poll, int_ack} = '0;
    alu_result = 8'h00;
    operand    = 8'h00;
    pull_data  = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    irq_n = 1'b1;
    nmi_n = 1'b1;
    push_brk = 1'b1;
    idle();
    expect_v("reset_flags", SEL_FLAGS, 8'h04);
    expect_v("reset_irq_take", SEL_IRQ, 8'h00);
    expect_v("reset_nmi_take", SEL_NMI, 8'h00);
    tick();
    check_all();
    rst_n = 1'b1;
    tick();
    expect_v("post_reset_flags", SEL_FLAGS, 8'h04);
    expect_v("post_reset_push", SEL_PUSH, 8'h34);
    check_all();

    // ALU update of all four flags
    alu_result = 8'h80; alu_carry = 1'b1; alu_overflow = 1'b1; alu_valid = 1'b1;
    {upd_n, upd_z, upd_c, upd_v} = 4'hF;
    expect_v("alu_all", SEL_FLAGS, 8'h35);
    tick(); idle(); check_all();

    alu_result = 8'h00; alu_valid = 1'b1; {upd_n, upd_z, upd_v} = 3'b111;
    expect_v("alu_zero_keep_c", SEL_FLAGS, 8'h07);
    tick(); idle(); check_all();

    // alu_valid low blocks all updates
    alu_result = 8'h80; alu_carry = 1'b0; {upd_n, upd_z, upd_c, upd_v} = 4'hF;
    expect_v("alu_invalid", SEL_FLAGS, 8'h07);
    tick(); idle(); check_all();

    // PLP beats everything else
    pull_data = 8'hFF; plp_load = 1'b1; clr_c = 1'b1;
    alu_valid = 1'b1; {upd_n, upd_z, upd_c, upd_v} = 4'hF;
    push_brk = 1'b0;
    expect_v("plp_priority", SEL_FLAGS, 8'h3F);
    expect_v("push_brk0", SEL_PUSH, 8'hEF);
    tick(); idle(); check_all();

    set_c = 1'b1; clr_c = 1'b1;
    expect_v("set_clr_c", SEL_FLAGS, 8'h3E);
    tick(); idle(); check_all();

    clr_d = 1'b1; clr_i = 1'b1; set_i = 1'b1;
    expect_v("clr_d_i", SEL_FLAGS, 8'h32);
    tick(); idle(); check_all();

    // BIT
    pull_data = 8'h31; plp_load = 1'b1;
    expect_v("plp_ignore_b5b4", SEL_FLAGS, 8'h01);
    tick(); idle(); check_all();

    operand = 8'hC0; alu_result = 8'h00; bit_op = 1'b1; alu_valid = 1'b1;
    expect_v("bit_c0", SEL_FLAGS, 8'h33);
    tick(); idle(); check_all();

    operand = 8'h00; alu_result = 8'h00; bit_op = 1'b1; upd_z = 1'b1;
    expect_v("bit_no_valid", SEL_FLAGS, 8'h03);
    tick(); idle(); check_all();

    operand = 8'h40; alu_result = 8'h85; bit_op = 1'b1; alu_valid = 1'b1;
    upd_n = 1'b1; upd_c = 1'b1; alu_carry = 1'b0;
    expect_v("bit_plus_alu_c", SEL_FLAGS, 8'h10);
    tick(); idle(); check_all();

    // IRQ recognition latency after CLI
    set_i = 1'b1;
    expect_v("sei", SEL_FLAGS, 8'h14);
    tick(); idle(); check_all();
    irq_n = 1'b0;
    ticks(4);
    expect_v("irq_masked", SEL_IRQ, 8'h00);
    check_all();
    clr_i = 1'b1;
    tick(); idle();
    poll = 1'b1;
    expect_v("irq_poll_early", SEL_IRQ, 8'h00);
    tick(); idle(); check_all();
    ticks(2);
    poll = 1'b1;
    expect_v("irq_poll_late", SEL_IRQ, 8'h01);
    tick(); idle(); check_all();
    expect_v("irq_hold", SEL_IRQ, 8'h01);
    tick(); check_all();
    int_ack = 1'b1;
    expect_v("irq_ack", SEL_IRQ, 8'h00);
    tick(); idle(); check_all();

    // NMI pulse beats pending IRQ
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    ticks(4);
    poll = 1'b1;
    expect_v("nmi_take_pulse", SEL_NMI, 8'h01);
    expect_v("nmi_over_irq", SEL_IRQ, 8'h00);
    tick(); idle(); check_all();
    int_ack = 1'b1;
    expect_v("nmi_ack", SEL_NMI, 8'h00);
    tick(); idle(); check_all();

    // Held-low NMI is taken once only
    nmi_n = 1'b0;
    ticks(4);
    poll = 1'b1;
    expect_v("nmi_take_held", SEL_NMI, 8'h01);
    tick(); idle(); check_all();
    int_ack = 1'b1;
    tick(); idle();
    poll = 1'b1;
    expect_v("nmi_no_retake", SEL_NMI, 8'h00);
    expect_v("irq_after_nmi", SEL_IRQ, 8'h01);
    tick(); idle(); check_all();
    ticks(3);
    poll = 1'b1;
    expect_v("nmi_no_retake2", SEL_NMI, 8'h00);
    tick(); idle(); check_all();

    // Async reset while NMI is being taken
    nmi_n = 1'b1;
    ticks(3);
    nmi_n = 1'b0;
    ticks(4);
    poll = 1'b1;
    expect_v("nmi_before_rst", SEL_NMI, 8'h01);
    tick(); idle(); check_all();
    rst_n = 1'b0;
    #1;
    expect_v("rst_nmi_take", SEL_NMI, 8'h00);
    expect_v("rst_irq_take", SEL_IRQ, 8'h00);
    expect_v("rst_flags", SEL_FLAGS, 8'h04);
    check_all();
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/status_flags.md
Name: status_flags

Overview:
- 6502 processor status register (P) and interrupt-pending logic.
- Sits on the consumer side of the ALU: takes its result and carry/overflow outputs and commits N/V/Z/C under per-flag update enables.
- Also handles explicit flag instructions (SEC/CLC/SEI/CLI/SED/CLD/CLV), PHP/PLP byte formatting, BIT, and IRQ/NMI qualification for the sequencer.

Parameters:
- RESET_I, 1, value of the I flag after reset.
- NMI_SYNC, 2, number of synchronizer flops on `nmi_n` and `irq_n`. Must be ≥1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alu_result  in  8  ALU output byte
- alu_carry  in  1  ALU carry out
- alu_overflow  in  1  ALU signed overflow
- alu_valid  in  1  ALU outputs are valid this cycle; qualifies all `upd_*`
- upd_n, upd_z, upd_c, upd_v  in  1 each  commit N/Z/C/V from the ALU when `alu_valid` is high
- bit_op  in  1  BIT instruction: N<=`operand[7]`, V<=`operand[6]`, Z<=(`alu_result`==0)
- operand  in  8  memory operand used by BIT
- set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v  in  1 each  explicit flag ops
- plp_load  in  1  load P from `pull_data` (PLP/RTI)
- pull_data  in  8  byte pulled from the stack
- push_brk  in  1  B bit value for `p_push`: 1 for PHP/BRK, 0 for IRQ/NMI
- p_push  out  8  {N,V,1,`push_brk`,D,I,Z,C}
- flag_n, flag_v, flag_d, flag_i, flag_z, flag_c  out  1 each  current flags
- irq_n  in  1  level-sensitive IRQ, active low, asynchronous
- nmi_n  in  1  edge-sensitive NMI, active low, asynchronous
- poll  in  1  sequencer at an instruction boundary
- int_ack  in  1  sequencer has entered the interrupt sequence
- irq_take  out  1  take IRQ at this boundary
- nmi_take  out  1  take NMI at this boundary

Behaviour:
- Reset, asynchronous:
  - N=V=D=Z=C=0, I=`RESET_I`.
  - NMI pending cleared; synchronizers reset to 1 (inactive).
  - `irq_take`=`nmi_take`=0; `i_delayed`=`RESET_I`.
- All flag updates are registered on the rising edge of `clk`. Flag outputs change the cycle after the request (latency 1).
- Write priority per flag, highest first:
  1. `plp_load`: all six flags from `pull_data` bits 7,6,3,2,1,0. Bits 5 and 4 ignored.
  2. Explicit set/clr. If set and clr are both asserted for the same flag, clr wins.
  3. `bit_op`: N and V from `operand`; Z from `alu_result` when `alu_valid`.
  4. ALU update: N<=`alu_result[7]`, Z<=~|`alu_result`, C<=`alu_carry`, V<=`alu_overflow`, each under its `upd_*` and `alu_valid`.
  - Lower-priority writes to flags not touched by a higher source still apply in the same cycle.
- `alu_valid`=0: `upd_*` and the Z part of `bit_op` are ignored. N/V from `bit_op` still load.
- `p_push` is combinational from the current flags and `push_brk`; bit 5 is always 1.
- NMI:
  - Synchronized, then falling-edge detected into `nmi_pending`.
  - `nmi_pending` stays set until `int_ack` is seen in a cycle where `nmi_take`=1.
  - A new falling edge in the same cycle as the clear re-sets `nmi_pending` (set wins).
- IRQ:
  - `irq_pend` = synchronized `irq_n`==0 AND `i_delayed`==0.
  - `i_delayed` is `flag_i` registered one cycle. This models the 6502 one-instruction latency of CLI/SEI/PLP on interrupt recognition.
- Take outputs:
  - At `poll`=1: `nmi_take`=`nmi_pending` (registered, valid the next cycle); `irq_take`=`irq_pend` AND NOT `nmi_pending`. NMI has priority.
  - Take outputs hold until `int_ack` or until `poll` is deasserted with no pending source; they are cleared the cycle after `int_ack`.
- The sequencer must assert `set_i` during the interrupt sequence; this block never sets I by itself.
- Reset mid-sequence: all pending/take state is cleared immediately, asynchronously.

Test Plan:
- Reset with `RESET_I`=1, then release → flags N V D I Z C = 0 0 0 1 0 0; `p_push` with `push_brk`=1 is 0x34.
- `alu_result`=0x80, `alu_carry`=1, `alu_overflow`=1, `alu_valid`=1, all `upd_*`=1 → next cycle N=1, Z=0, C=1, V=1. Repeat with `alu_result`=0x00, `upd_c`=0 → Z=1, N=0, C stays 1.
- Priority: `plp_load` with `pull_data`=0xFF, plus `clr_c` and an ALU update, all in one cycle → all flags 1, `p_push` (`push_brk`=0)=0xEF. Then `set_c` and `clr_c` in the same cycle → C=0.
- BIT: `operand`=0xC0, `alu_result`=0x00, `bit_op`=1, `alu_valid`=1 → N=1, V=1, Z=1, C unchanged.
- IRQ latency: I=1, `irq_n`=0, `clr_i` at cycle t, `poll` at t+1 → `irq_take`=0; `poll` at t+NMI_SYNC+2 → `irq_take`=1. `int_ack` → `irq_take` drops the next cycle.
- NMI priority and edge:
  - `irq_n`=0, I=0, then a single 1-cycle low pulse on `nmi_n`, then `poll` → `nmi_take`=1, `irq_take`=0.
  - After `int_ack`, `nmi_n` held low produces no second `nmi_take`.
  - Asserting `rst_n`=0 while pending clears `nmi_take` immediately.
